fft_output_buffer: RTL and testbench

//  Receive-side counterpart of the FFT input path: takes the FFT core's output burst of NSamples

---
 rtl/fft_buffer_pkg.sv | 18 +
 rtl/fft_power_calc.sv | 43 ++++
 rtl/fft_output_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_fft_output_buffer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_buffer_pkg.sv
// Shared types and helpers for the FFT output buffer: bank life-cycle states,
// bank count and the address-width helper.
package fft_buffer_pkg;

   typedef enum logic [1:0] {
      BANK_FREE,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_state_t;

   localparam int NBANKS = 2;

   function automatic int addr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fft_power_calc.sv
// Squared magnitude of one complex bin, scaled down by 2^(W-1) and saturated to W bits.
// Single register stage; valid and sop travel alongside the result.
module fft_power_calc
   import fft_buffer_pkg::*;
#(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic signed [W-1:0] re,
   input  logic signed [W-1:0] im,
   input  logic                in_valid,
   input  logic                in_sop,
   output logic [W-1:0]        power,
   output logic                out_valid,
   output logic                out_sop
);

   logic signed [2*W-1:0] re_ext;
   logic signed [2*W-1:0] im_ext;
   logic [2*W-1:0]        sum;
   logic [W-1:0]          power_next;

   assign re_ext = (2*W)'(re);
   assign im_ext = (2*W)'(im);

   // Only (-2^(W-1))^2 * 2 reaches the top bit; everything else fits the slice.
   assign sum        = unsigned'(re_ext * re_ext) + unsigned'(im_ext * im_ext);
   assign power_next = sum[2*W-1] ? '1 : sum[2*W-2:W-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         power     <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
      end else begin
         power     <= power_next;
         out_valid <= in_valid;
         out_sop   <= in_valid && in_sop;
      end
   end

endmodule

// File: rtl/fft_output_buffer.sv
// Frames FFT power bins into a two-bank ping-pong RAM and streams each completed
// frame out over ready/valid through a 2-entry skid; frames with no free bank are dropped.
module fft_output_buffer
   import fft_buffer_pkg::*;
#(
   parameter int W        = 16,
   parameter int NSamples = 1024
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic signed [W-1:0] fft_real,
   input  logic signed [W-1:0] fft_imag,
   input  logic                fft_valid,
   input  logic                fft_sop,
   output logic [W-1:0]        power_output_data,
   output logic                power_output_valid,
   input  logic                power_output_ready,
   output logic                frame_start,
   output logic                overflow
);

   localparam int AW = addr_width(NSamples);
   localparam logic [AW-1:0] LAST_IDX = AW'(NSamples - 1);

   logic [W-1:0] pw_data;
   logic         pw_valid;
   logic         pw_sop;

   fft_power_calc #(.W(W)) u_power (
      .clk       (clk),
      .reset_n   (reset_n),
      .re        (fft_real),
      .im        (fft_imag),
      .in_valid  (fft_valid),
      .in_sop    (fft_sop),
      .power     (pw_data),
      .out_valid (pw_valid),
      .out_sop   (pw_sop)
   );

   bank_state_t   bank_state_reg  [NBANKS];
   bank_state_t   bank_state_next [NBANKS];
   logic          wr_bank_reg, wr_bank_next;
   logic [AW-1:0] wr_cnt_reg, wr_cnt_next;
   logic          overflow_reg, overflow_next;
   logic          wr_en;
   logic [AW:0]   wr_addr;

   logic          rd_active_reg, rd_active_next;
   logic          rd_bank_reg, rd_bank_next;
   logic [AW-1:0] rd_cnt_reg, rd_cnt_next;
   logic          rd_done_reg, rd_done_next;
   logic          rd_issue;
   logic [AW:0]   rd_addr;
   logic          inflight_reg, inflight_sop_reg, inflight_last_reg;

   logic [W-1:0]  ram [2*NSamples];
   logic [W-1:0]  ram_q;

   logic [W-1:0]  skid_data_reg [2];
   logic          skid_sop_reg  [2];
   logic          skid_last_reg [2];
   logic          skid_head_reg;
   logic [1:0]    skid_cnt_reg;
   logic          skid_tail;

   logic          filling;
   logic          pop;
   logic          last_pop;

   assign filling  = (bank_state_reg[0] == BANK_FILLING) || (bank_state_reg[1] == BANK_FILLING);
   assign pop      = power_output_valid && power_output_ready;
   assign last_pop = pop && skid_last_reg[skid_head_reg];
   assign rd_addr  = {rd_bank_reg, rd_cnt_reg};

   // Issue a read only if the skid can absorb it, counting words already in flight.
   assign rd_issue = rd_active_reg && !rd_done_reg &&
                     (({1'b0, skid_cnt_reg} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));

   always_comb begin
      for (int b = 0; b < NBANKS; b++) bank_state_next[b] = bank_state_reg[b];
      wr_bank_next   = wr_bank_reg;
      wr_cnt_next    = wr_cnt_reg;
      overflow_next  = overflow_reg;
      wr_en          = 1'b0;
      wr_addr        = {wr_bank_reg, wr_cnt_reg};
      rd_active_next = rd_active_reg;
      rd_bank_next   = rd_bank_reg;
      rd_cnt_next    = rd_cnt_reg;
      rd_done_next   = rd_done_reg;

      // Write side: decisions use registered bank state, so a bank freed this cycle is not yet FREE.
      if (pw_valid && pw_sop) begin
         if (filling) begin
            wr_en       = 1'b1;
            wr_addr     = {wr_bank_reg, AW'(0)};
            wr_cnt_next = AW'(1);
         end else if (bank_state_reg[0] == BANK_FREE || bank_state_reg[1] == BANK_FREE) begin
            wr_bank_next                  = (bank_state_reg[0] == BANK_FREE) ? 1'b0 : 1'b1;
            bank_state_next[wr_bank_next] = BANK_FILLING;
            wr_en                         = 1'b1;
            wr_addr                       = {wr_bank_next, AW'(0)};
            wr_cnt_next                   = AW'(1);
         end else begin
            overflow_next = 1'b1;
         end
      end else if (pw_valid && filling) begin
         wr_en       = 1'b1;
         wr_cnt_next = wr_cnt_reg + AW'(1);
         if (wr_cnt_reg == LAST_IDX) bank_state_next[wr_bank_reg] = BANK_FULL;
      end

      if (rd_issue) begin
         rd_cnt_next = rd_cnt_reg + AW'(1);
         if (rd_cnt_reg == LAST_IDX) rd_done_next = 1'b1;
      end

      if (last_pop) begin
         bank_state_next[rd_bank_reg] = BANK_FREE;
         rd_active_next               = 1'b0;
      end

      // A waiting frame is picked up in the same cycle the previous one finishes.
      if ((!rd_active_reg || last_pop) &&
          (bank_state_reg[0] == BANK_FULL || bank_state_reg[1] == BANK_FULL)) begin
         rd_bank_next                  = (bank_state_reg[0] == BANK_FULL) ? 1'b0 : 1'b1;
         bank_state_next[rd_bank_next] = BANK_DRAINING;
         rd_active_next                = 1'b1;
         rd_cnt_next                   = '0;
         rd_done_next                  = 1'b0;
      end
   end

   for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) bank_state_reg[gi] <= BANK_FREE;
         else          bank_state_reg[gi] <= bank_state_next[gi];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)    ram[wr_addr] <= pw_data;
      if (rd_issue) ram_q        <= ram[rd_addr];
   end

   assign skid_tail = skid_head_reg ^ skid_cnt_reg[0];

   for (genvar gi = 0; gi < 2; gi++) begin : g_skid
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            skid_data_reg[gi] <= '0;
            skid_sop_reg[gi]  <= 1'b0;
            skid_last_reg[gi] <= 1'b0;
         end else if (inflight_reg && (skid_tail == 1'(gi))) begin
            skid_data_reg[gi] <= ram_q;
            skid_sop_reg[gi]  <= inflight_sop_reg;
            skid_last_reg[gi] <= inflight_last_reg;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank_reg       <= 1'b0;
         wr_cnt_reg        <= '0;
         overflow_reg      <= 1'b0;
         rd_active_reg     <= 1'b0;
         rd_bank_reg       <= 1'b0;
         rd_cnt_reg        <= '0;
         rd_done_reg       <= 1'b0;
         inflight_reg      <= 1'b0;
         inflight_sop_reg  <= 1'b0;
         inflight_last_reg <= 1'b0;
         skid_head_reg     <= 1'b0;
         skid_cnt_reg      <= 2'd0;
      end else begin
         wr_bank_reg       <= wr_bank_next;
         wr_cnt_reg        <= wr_cnt_next;
         overflow_reg      <= overflow_next;
         rd_active_reg     <= rd_active_next;
         rd_bank_reg       <= rd_bank_next;
         rd_cnt_reg        <= rd_cnt_next;
         rd_done_reg       <= rd_done_next;
         inflight_reg      <= rd_issue;
         inflight_sop_reg  <= rd_issue && (rd_cnt_reg == '0);
         inflight_last_reg <= rd_issue && (rd_cnt_reg == LAST_IDX);
         if (pop) skid_head_reg <= ~skid_head_reg;
         case ({inflight_reg, pop})
            2'b10:   skid_cnt_reg <= skid_cnt_reg + 2'd1;
            2'b01:   skid_cnt_reg <= skid_cnt_reg - 2'd1;
            default: skid_cnt_reg <= skid_cnt_reg;
         endcase
      end
   end

   assign power_output_valid = (skid_cnt_reg != 2'd0);
   assign power_output_data  = skid_data_reg[skid_head_reg];
   assign frame_start        = power_output_valid && skid_sop_reg[skid_head_reg];
   assign overflow           = overflow_reg;

endmodule

// File: tb/tb_fft_output_buffer.sv
// Bench for fft_output_buffer: table-driven power vectors, randomized frames against a
// frame-level reference model, and hand-written overflow / restart / reset sequences.
module tb_fft_output_buffer;

   localparam int W  = 16;
   localparam int NS = 16;

   typedef struct {
      logic [W-1:0] data;
      logic         fs;
   } word_t;

   typedef struct {
      logic signed [W-1:0] re;
      logic signed [W-1:0] im;
      logic [W-1:0]        exp;
   } vec_t;

   logic                clk = 1'b0;
   logic                reset_n = 1'b1;
   logic signed [W-1:0] fft_real = '0;
   logic signed [W-1:0] fft_imag = '0;
   logic                fft_valid = 1'b0;
   logic                fft_sop = 1'b0;
   logic [W-1:0]        power_output_data;
   logic                power_output_valid;
   logic                power_output_ready;
   logic                frame_start;
   logic                overflow;

   logic ready_fixed = 1'b1;
   logic ready_rand  = 1'b0;
   logic rand_ready  = 1'b0;
   assign power_output_ready = rand_ready ? ready_rand : ready_fixed;

   int checks   = 0;
   int failures = 0;
   int rx_total = 0;

   word_t rx_q[$];
   word_t exp_q[$];
   vec_t  vecs[8];
   logic signed [W-1:0] fr_re[NS];
   logic signed [W-1:0] fr_im[NS];
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;

   fft_output_buffer #(.W(W), .NSamples(NS)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .fft_real           (fft_real),
      .fft_imag           (fft_imag),
      .fft_valid          (fft_valid),
      .fft_sop            (fft_sop),
      .power_output_data  (power_output_data),
      .power_output_valid (power_output_valid),
      .power_output_ready (power_output_ready),
      .frame_start        (frame_start),
      .overflow           (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] model_power(input logic signed [W-1:0] re,
                                                input logic signed [W-1:0] im);
      longint p;
      p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (p >= 64'sd2147483648) return '1;
      return W'(p / 32768);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int n);
      for (int i = 0; i < n; i++) begin
         fft_valid = 1'b1;
         fft_sop   = (i == 0);
         fft_real  = fr_re[i];
         fft_imag  = fr_im[i];
         tick();
      end
      fft_valid = 1'b0;
      fft_sop   = 1'b0;
   endtask

   task automatic random_frame();
      for (int i = 0; i < NS; i++) begin
         fr_re[i] = W'($urandom);
         fr_im[i] = W'($urandom);
      end
   endtask

   task automatic push_exp_frame();
      word_t w;
      for (int i = 0; i < NS; i++) begin
         w.data = model_power(fr_re[i], fr_im[i]);
         w.fs   = (i == 0);
         exp_q.push_back(w);
      end
   endtask

   task automatic wait_rx(input int n, input string name);
      int c = 0;
      while (rx_q.size() < n && c < 4000) begin
         tick();
         c++;
      end
      chk({name, "_complete"}, 32'(rx_q.size() >= n), 32'd1);
   endtask

   task automatic drain_and_compare(input string name);
      int    n;
      word_t a;
      word_t e;
      n = exp_q.size();
      wait_rx(n, name);
      repeat (8) tick();
      chk({name, "_count"}, 32'(rx_q.size()), 32'(n));
      for (int i = 0; i < n && rx_q.size() > 0; i++) begin
         a = rx_q.pop_front();
         e = exp_q.pop_front();
         chk($sformatf("%s_data[%0d]", name, i), 32'(a.data), 32'(e.data));
         chk($sformatf("%s_fs[%0d]", name, i), 32'(a.fs), 32'(e.fs));
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      fft_valid = 1'b0;
      fft_sop   = 1'b0;
      reset_n   = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int    base;
      int    c;
      word_t w;

      vecs[0] = '{16'sd16384, 16'sd0,     16'h2000};
      vecs[1] = '{16'h8000,   16'h8000,   16'hFFFF};
      vecs[2] = '{16'sd3,     16'sd4,     16'h0000};
      vecs[3] = '{16'h8000,   16'sd0,     16'h8000};
      vecs[4] = '{16'sd32767, 16'sd32767, 16'hFFFC};
      vecs[5] = '{16'sd181,   16'sd181,   16'h0001};
      vecs[6] = '{16'sd0,     -16'sd256,  16'h0002};
      vecs[7] = '{16'sd1000,  -16'sd2000, 16'h0098};

      fork
         forever begin
            @(negedge clk);
            if (!reset_n) begin
               prev_stall = 1'b0;
            end else begin
               if (prev_stall) begin
                  chk("hold_valid", 32'(power_output_valid), 32'd1);
                  chk("hold_data", 32'(power_output_data), 32'(prev_data));
               end
               if (power_output_valid && power_output_ready) begin
                  w.data = power_output_data;
                  w.fs   = frame_start;
                  rx_q.push_back(w);
                  rx_total++;
               end
               prev_stall = power_output_valid && !power_output_ready;
               prev_data  = power_output_data;
            end
         end
         forever begin
            @(posedge clk);
            #1;
            ready_rand = 1'($urandom_range(0, 1));
         end
      join_none

      #1 reset_n = 1'b0;
      #1;
      chk("reset_valid", 32'(power_output_valid), 32'd0);
      chk("reset_data", 32'(power_output_data), 32'd0);
      chk("reset_frame_start", 32'(frame_start), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Constant-magnitude frame
      for (int i = 0; i < NS; i++) begin
         fr_re[i] = 16'sd16384;
         fr_im[i] = 16'sd0;
      end
      send_frame(NS);
      wait_rx(NS, "t1");
      repeat (4) tick();
      chk("t1_count", 32'(rx_q.size()), 32'(NS));
      for (int i = 0; i < rx_q.size(); i++) begin
         chk($sformatf("t1_data[%0d]", i), 32'(rx_q[i].data), 32'h2000);
         chk($sformatf("t1_fs[%0d]", i), 32'(rx_q[i].fs), 32'(i == 0));
      end
      rx_q.delete();

      // Vector table, including saturation and truncation cases
      for (int i = 0; i < NS; i++) begin
         fr_re[i] = vecs[i % 8].re;
         fr_im[i] = vecs[i % 8].im;
      end
      send_frame(NS);
      wait_rx(NS, "t2");
      repeat (4) tick();
      chk("t2_count", 32'(rx_q.size()), 32'(NS));
      for (int i = 0; i < rx_q.size(); i++) begin
         chk($sformatf("t2_vec[%0d]", i), 32'(rx_q[i].data), 32'(vecs[i % 8].exp));
         chk($sformatf("t2_fs[%0d]", i), 32'(rx_q[i].fs), 32'(i == 0));
      end
      rx_q.delete();

      // Random data, random backpressure; a frame is sent only once two banks can hold it
      rand_ready = 1'b1;
      base = rx_total;
      for (int k = 0; k < 6; k++) begin
         c = 0;
         while ((rx_total - base) < (k - 1) * NS && c < 3000) begin
            tick();
            c++;
         end
         chk($sformatf("t3_throttle[%0d]", k), 32'((rx_total - base) >= (k - 1) * NS), 32'd1);
         random_frame();
         send_frame(NS);
         push_exp_frame();
      end
      drain_and_compare("t3");
      chk("t3_overflow", 32'(overflow), 32'd0);
      rand_ready = 1'b0;

      // Three frames with the consumer stalled: third dropped, overflow sticky
      ready_fixed = 1'b0;
      for (int k = 0; k < 3; k++) begin
         random_frame();
         send_frame(NS);
         if (k < 2) push_exp_frame();
      end
      repeat (4) tick();
      chk("t4_overflow_set", 32'(overflow), 32'd1);
      chk("t4_nothing_out", 32'(rx_q.size()), 32'd0);
      ready_fixed = 1'b1;
      drain_and_compare("t4");
      chk("t4_overflow_sticky", 32'(overflow), 32'd1);

      // Partial frame interrupted by a new sop
      do_reset();
      chk("t5_overflow_cleared", 32'(overflow), 32'd0);
      random_frame();
      send_frame(10);
      random_frame();
      send_frame(NS);
      push_exp_frame();
      drain_and_compare("t5");
      chk("t5_overflow", 32'(overflow), 32'd0);

      // Asynchronous reset in the middle of a drain
      random_frame();
      base = rx_total;
      send_frame(NS);
      c = 0;
      while (rx_total < base + 5 && c < 200) begin
         tick();
         c++;
      end
      chk("t6_drain_started", 32'(rx_total >= base + 5), 32'd1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_valid_async", 32'(power_output_valid), 32'd0);
      chk("t6_fs_async", 32'(frame_start), 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      rx_q.delete();
      exp_q.delete();
      repeat (30) tick();
      chk("t6_no_words", 32'(rx_q.size()), 32'd0);
      chk("t6_valid_idle", 32'(power_output_valid), 32'd0);
      random_frame();
      send_frame(NS);
      push_exp_frame();
      drain_and_compare("t6_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
